led_matrix_scanner: RTL and testbench

//  Downstream display stage for the 8x8 snake game: consumes the 64-bit frame

---
 rtl/snake_pkg.sv | 40 ++++
 rtl/led_matrix_scanner.sv | 133 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Shared definitions for the 8x8 snake game slice: grid geometry, the packed
//   frame-image width and the LED matrix scanner state encoding. The game core
//   imports this same package, so geometry lives in one place.
//
//   Contents:
//     GRID_W, GRID_H  grid width/height in cells
//     PIX_W           width of the packed frame image (GRID_W*GRID_H)
//     ROW_IDX_W       width of a row index
//     scan_state_t    scanner FSM states (IDLE / SHOW / BLANK)
//     row_onehot()    one-hot row select for a row index
//     row_slice()     column data for one row of a packed frame image
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W    = 8;
    localparam int GRID_H    = 8;
    localparam int PIX_W     = GRID_W * GRID_H;
    localparam int ROW_IDX_W = $clog2(GRID_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Row y of the matrix is lit by driving bit y of the row bus high.
    function automatic logic [GRID_H-1:0] row_onehot(input logic [ROW_IDX_W-1:0] idx);
        return GRID_H'(1) << idx;
    endfunction

    // The image is packed row-major: cell (x,y) lives at bit {y,x}, so row y
    // is the GRID_W-bit slice starting at y*GRID_W.
    function automatic logic [GRID_W-1:0] row_slice(input logic [PIX_W-1:0]     img,
                                                    input logic [ROW_IDX_W-1:0] idx);
        return img[int'(idx) * GRID_W +: GRID_W];
    endfunction

endpackage

// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//   Display stage for the 8x8 snake game. Latches a whole frame image at frame
//   start, then scans it onto a row-multiplexed LED matrix one row at a time,
//   with an all-dark gap after each row to suppress ghosting. Because the image
//   is latched, game updates arriving mid-frame never tear the picture.
//
//   Parameters:
//     ROW_TICKS    clk cycles each row is lit (>= 1)
//     BLANK_TICKS  clk cycles all-dark after each row (0 = no blanking)
//
//   Ports:
//     clk          clock
//     rst_n        asynchronous, active-low reset
//     en           scan enable; low forces the display dark and the FSM idle
//     pix[63:0]    frame image, bit {y,x} = cell (x,y)
//     row[7:0]     one-hot active-high row select
//     col[7:0]     column data for the selected row
//     frame_start  one-cycle pulse on the cycle a new image is latched
//
//   All outputs are registered. Frame period = 8*(ROW_TICKS+BLANK_TICKS).
// -----------------------------------------------------------------------------
module led_matrix_scanner
    import snake_pkg::*;
#(
    parameter int ROW_TICKS   = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix,
    output logic [GRID_H-1:0] row,
    output logic [GRID_W-1:0] col,
    output logic              frame_start
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    // Terminal counts for each lit/dark phase. With blanking disabled the
    // BLANK state is unreachable, so its terminal count is a don't-care zero.
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CNT_W'(BLANK_TICKS - 1)
                                                                : '0;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(GRID_H - 1);

    scan_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [ROW_IDX_W-1:0]   row_idx;
    logic [PIX_W-1:0]       frame_buf;

    logic                   row_done;
    logic                   reload;
    logic [ROW_IDX_W-1:0]   next_idx;

    // row_done marks the last cycle of a row slot: the end of the blank gap,
    // or the end of the lit phase when there is no blank gap at all.
    always_comb begin
        row_done = 1'b0;
        case (state)
            SHOW:    row_done = (cnt == ROW_LAST) && (BLANK_TICKS == 0);
            BLANK:   row_done = (cnt == BLANK_LAST);
            default: row_done = 1'b0;
        endcase
    end

    // A fresh image is latched when leaving IDLE and after the last row, so
    // consecutive frames run back to back with no idle gap.
    assign reload   = (state == IDLE) || (row_done && (row_idx == LAST_ROW));
    assign next_idx = row_idx + ROW_IDX_W'(1);

    // Scanner FSM. Outputs are computed one cycle ahead so that the row/col
    // seen on the pins always matches the state the FSM has just entered.
    // Dropping en abandons the frame at once; the next enable re-latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            row_idx     <= '0;
            frame_buf   <= '0;
            row         <= '0;
            col         <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            cnt         <= '0;
            row_idx     <= '0;
            row         <= '0;
            col         <= '0;
            frame_start <= 1'b0;
        end else if (reload) begin
            state       <= SHOW;
            cnt         <= '0;
            row_idx     <= '0;
            frame_buf   <= pix;
            row         <= row_onehot('0);
            col         <= row_slice(pix, '0);
            frame_start <= 1'b1;
        end else if (row_done) begin
            state       <= SHOW;
            cnt         <= '0;
            row_idx     <= next_idx;
            row         <= row_onehot(next_idx);
            col         <= row_slice(frame_buf, next_idx);
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                SHOW: begin
                    if (cnt == ROW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        row   <= '0;
                        col   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    row   <= '0;
                    col   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
//   Two scanner instances share the stimulus: one with default timing and one
//   with single-cycle rows and no blanking. A time-based model (cycles since
//   the last latch) predicts each instance's outputs every cycle; predictions
//   are queued at the clock edge and popped and compared half a cycle later.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

    localparam int A_ROW   = 4;
    localparam int A_BLANK = 1;
    localparam int B_ROW   = 1;
    localparam int B_BLANK = 0;

    localparam logic [63:0] SNAKE_IMG = 64'h0000_0000_0F00_0000;
    localparam logic [63:0] FULL_IMG  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [63:0] pix   = '0;

    logic [7:0]  row_a, col_a, row_b, col_b;
    logic        fs_a, fs_b;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    led_matrix_scanner #(.ROW_TICKS(A_ROW), .BLANK_TICKS(A_BLANK)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pix(pix),
        .row(row_a), .col(col_a), .frame_start(fs_a)
    );

    led_matrix_scanner #(.ROW_TICKS(B_ROW), .BLANK_TICKS(B_BLANK)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .pix(pix),
        .row(row_b), .col(col_b), .frame_start(fs_b)
    );

    // Reference model state: whether a frame is running, cycles since it was
    // latched, and the latched image.
    bit          act_a, act_b;
    int          t_a, t_b;
    logic [63:0] img_a, img_b;
    logic [16:0] exp_q_a[$];
    logic [16:0] exp_q_b[$];

    // Expected {frame_start,row,col} t cycles into a frame: each row owns a
    // slot of rt+bt cycles, lit for the first rt of them.
    function automatic logic [16:0] model_out(input bit act, input int t,
                                              input logic [63:0] img,
                                              input int rt, input int bt);
        int          slot;
        int          y;
        int          ph;
        logic [7:0]  rr;
        logic [7:0]  cc;
        logic        fs;
        if (!act) return 17'd0;
        slot = rt + bt;
        y    = t / slot;
        ph   = t % slot;
        rr   = 8'h00;
        cc   = 8'h00;
        if (ph < rt) begin
            rr = 8'h01 << y;
            cc = img[8*y +: 8];
        end
        fs = (t == 0);
        return {fs, rr, cc};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            act_a = 0; t_a = 0;
            act_b = 0; t_b = 0;
        end else if (!en) begin
            act_a = 0;
            act_b = 0;
        end else begin
            if (!act_a) begin
                act_a = 1; t_a = 0; img_a = pix;
            end else begin
                t_a++;
                if (t_a == 8*(A_ROW+A_BLANK)) begin t_a = 0; img_a = pix; end
            end
            if (!act_b) begin
                act_b = 1; t_b = 0; img_b = pix;
            end else begin
                t_b++;
                if (t_b == 8*(B_ROW+B_BLANK)) begin t_b = 0; img_b = pix; end
            end
        end
        exp_q_a.push_back(model_out(act_a, t_a, img_a, A_ROW, A_BLANK));
        exp_q_b.push_back(model_out(act_b, t_b, img_b, B_ROW, B_BLANK));
    end

    // An asynchronous reset clears outputs before the next edge, so the
    // prediction still waiting to be compared becomes all-zero.
    always @(negedge rst_n) begin
        act_a = 0; t_a = 0;
        act_b = 0; t_b = 0;
        if (exp_q_a.size() > 0) exp_q_a[$] = '0;
        if (exp_q_b.size() > 0) exp_q_b[$] = '0;
    end

    task automatic checkOutput(input string name, input logic [16:0] exp_v,
                               input logic [16:0] act_v);
        check_count++;
        if (act_v === exp_v) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got fs=%0b row=%02h col=%02h, expected fs=%0b row=%02h col=%02h",
                     name, $time, act_v[16], act_v[15:8], act_v[7:0],
                     exp_v[16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q_a.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_a at %0t: got empty queue, expected a prediction", $time);
        end else begin
            checkOutput("scan_a", exp_q_a.pop_front(), {fs_a, row_a, col_a});
        end
        if (exp_q_b.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_b at %0t: got empty queue, expected a prediction", $time);
        end else begin
            checkOutput("scan_b", exp_q_b.pop_front(), {fs_b, row_b, col_b});
        end
    end

    // Drive en/pix and hold them for a number of cycles (called at a negedge).
    task automatic applyStimulus(input bit en_v, input logic [63:0] pix_v, input int cycles);
        en  = en_v;
        pix = pix_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_frame_start(input int which, output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if ((which == 0) ? fs_a : fs_b) ok = 1;
        end
        if (!ok) begin
            check_count++;
            $display("[TB] FAIL frame_start_timeout_%0d: got no pulse in %0d cycles, expected one", which, n);
        end
    endtask

    task automatic measure_period(input int which, input int expected);
        bit ok;
        bit seen;
        int n;
        wait_frame_start(which, ok);
        if (ok) begin
            n    = 0;
            seen = 0;
            while (!seen && n < 200) begin
                @(negedge clk);
                n++;
                if ((which == 0) ? fs_a : fs_b) seen = 1;
            end
            check_count++;
            if (seen && n == expected) begin
                pass_count++;
            end else begin
                $display("[TB] FAIL frame_period_%0d: got %0d cycles, expected %0d", which, n, expected);
            end
        end
    endtask

    initial begin
        bit ok;
        logic [63:0] rnd_pix;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_a", 17'd0, {fs_a, row_a, col_a});
        checkOutput("reset_b", 17'd0, {fs_b, row_b, col_b});
        rst_n = 1'b1;

        // Snake on row 3, then frame period for both timings.
        applyStimulus(1'b1, SNAKE_IMG, 45);
        measure_period(0, 8*(A_ROW+A_BLANK));
        measure_period(1, 8*(B_ROW+B_BLANK));

        // Image change during row 2 must not reach the current frame.
        wait_frame_start(0, ok);
        applyStimulus(1'b1, SNAKE_IMG, 10);
        applyStimulus(1'b1, FULL_IMG, 60);

        // Drop enable during row 5, then restart.
        applyStimulus(1'b1, SNAKE_IMG, 1);
        wait_frame_start(0, ok);
        applyStimulus(1'b1, SNAKE_IMG, 25);
        applyStimulus(1'b0, SNAKE_IMG, 3);
        applyStimulus(1'b1, SNAKE_IMG, 12);

        // Random images and occasional enable drops.
        rnd_pix = SNAKE_IMG;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) rnd_pix = {$urandom(), $urandom()};
            applyStimulus($urandom_range(0, 29) != 0, rnd_pix, 1);
        end

        // Asynchronous reset during a blank gap, then recovery.
        applyStimulus(1'b1, SNAKE_IMG, 2);
        wait_frame_start(0, ok);
        repeat (A_ROW) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_a", 17'd0, {fs_a, row_a, col_a});
        checkOutput("async_reset_b", 17'd0, {fs_b, row_b, col_b});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, SNAKE_IMG, 45);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
